// File: rtl/lsu_byte_serial.sv
// lsu_byte_serial: byte-serial load/store unit between the core and a byte-wide data memory.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only while idle)
//   req_store, req_funct3     operation: store flag and RISC-V size/sign code
//   req_addr, req_wdata       byte address (low ADDR_W bits used) and store data
//   rsp_valid                 one-cycle completion pulse
//   rsp_rdata, rsp_err        extended load data / illegal-funct3 flag
//   mem_wr_en/addr/data       byte write port
//   mem_rd_addr, mem_rd_data  byte read port (combinational read data)
module lsu_byte_serial #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [7:0]        mem_wr_data,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t            state_q;
    logic              store_q;
    logic              sgn_q;
    logic [1:0]        size_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic [31:0]       asm_d;
    logic [31:0]       ext;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              illegal;
    logic [1:0]        last_idx;
    logic              unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W];
    // stores have no unsigned variants, so BU/HU codes are illegal for them
    assign illegal  = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_store && req_funct3[2]);
    assign last_idx = size_q == 2'd2 ? 2'd3 : size_q == 2'd1 ? 2'd1 : 2'd0;
    assign req_ready   = state_q == IDLE;
    assign rsp_valid   = state_q == DONE;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign mem_wr_en   = state_q == ACCESS && store_q;
    assign mem_rd_addr = base_q + ADDR_W'(cnt_q);
    assign mem_wr_addr = mem_rd_addr;
    assign mem_wr_data = wdata_q[{cnt_q, 3'b000} +: 8];
    // assembly value including the byte arriving this cycle, so the last byte
    // can be extended straight into the response register
    always_comb begin
        asm_d = asm_q;
        asm_d[{cnt_q, 3'b000} +: 8] = mem_rd_data;
        ext = size_q == 2'd2 ? asm_d :
              size_q == 2'd1 ? {{16{sgn_q & asm_d[15]}}, asm_d[15:0]} :
                               {{24{sgn_q & asm_d[7]}}, asm_d[7:0]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= 2'd0;
            cnt_q   <= 2'd0;
            base_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    store_q <= req_store;
                    size_q  <= req_funct3[1:0];
                    sgn_q   <= ~req_funct3[2];
                    base_q  <= req_addr[ADDR_W-1:0];
                    wdata_q <= req_wdata;
                    asm_q   <= '0;
                    cnt_q   <= 2'd0;
                    if (illegal) begin
                        state_q <= DONE;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!store_q) asm_q <= asm_d;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == last_idx) begin
                        state_q <= DONE;
                        rdata_q <= store_q ? 32'd0 : ext;
                        err_q   <= 1'b0;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_byte_serial.sv
// tb_lsu_byte_serial: directed table-driven bench for lsu_byte_serial with a byte memory model.
module tb_lsu_byte_serial;
    localparam int ADDR_W = 5;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_store = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [31:0]       req_addr = 32'd0;
    logic [31:0]       req_wdata = 32'd0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [7:0]        mem_wr_data;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_rd_data;
    logic [7:0]        mem [0:31];
    lsu_byte_serial #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
    );
    always #5 clk = ~clk;
    assign mem_rd_data = mem[mem_rd_addr];
    always @(posedge clk) if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        err;
        int          nb;
    } vec_t;
    vec_t v [18];
    int total = 0;
    int bad = 0;
    int lat, nwr;
    logic [31:0] r_rdata;
    logic r_err, r_ready;
    logic [ADDR_W-1:0] seen [4];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1; nwr = 0; r_rdata = 32'hxxxxxxxx; r_err = 1'bx;
        for (int c = 1; c <= 10; c++) begin
            if (mem_wr_en) nwr++;
            if (c <= 4) seen[c-1] = mem_rd_addr;
            if (rsp_valid) begin
                lat = c; r_rdata = rsp_rdata; r_err = rsp_err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        r_ready = req_ready;
        if (mem_wr_en) nwr++;
    endtask
    initial begin
        int pulses;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
        v[0]  = '{1'b0, 3'b010, 32'd4,          32'd0,          32'h07060504, 1'b0, 4};
        v[1]  = '{1'b1, 3'b010, 32'd8,          32'hDEADBEEF,   32'h00000000, 1'b0, 4};
        v[2]  = '{1'b0, 3'b010, 32'd8,          32'd0,          32'hDEADBEEF, 1'b0, 4};
        v[3]  = '{1'b1, 3'b000, 32'd3,          32'h00000080,   32'h00000000, 1'b0, 1};
        v[4]  = '{1'b0, 3'b000, 32'd3,          32'd0,          32'hFFFFFF80, 1'b0, 1};
        v[5]  = '{1'b0, 3'b100, 32'd3,          32'd0,          32'h00000080, 1'b0, 1};
        v[6]  = '{1'b1, 3'b001, 32'd2,          32'h00008001,   32'h00000000, 1'b0, 2};
        v[7]  = '{1'b0, 3'b001, 32'd2,          32'd0,          32'hFFFF8001, 1'b0, 2};
        v[8]  = '{1'b0, 3'b101, 32'd2,          32'd0,          32'h00008001, 1'b0, 2};
        v[9]  = '{1'b0, 3'b010, 32'd30,         32'd0,          32'h01001F1E, 1'b0, 4};
        v[10] = '{1'b0, 3'b011, 32'd5,          32'd0,          32'h00000000, 1'b1, 0};
        v[11] = '{1'b1, 3'b100, 32'd5,          32'hFFFFFFFF,   32'h00000000, 1'b1, 0};
        v[12] = '{1'b1, 3'b101, 32'd6,          32'hFFFFFFFF,   32'h00000000, 1'b1, 0};
        v[13] = '{1'b0, 3'b111, 32'd0,          32'd0,          32'h00000000, 1'b1, 0};
        v[14] = '{1'b0, 3'b000, 32'hFFFFFFE5,   32'd0,          32'h00000005, 1'b0, 1};
        v[15] = '{1'b0, 3'b010, 32'd2,          32'd0,          32'h05048001, 1'b0, 4};
        v[16] = '{1'b0, 3'b001, 32'd31,         32'd0,          32'h0000001F, 1'b0, 2};
        v[17] = '{1'b0, 3'b001, 32'd10,         32'd0,          32'hFFFFDEAD, 1'b0, 2};
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset wr_en", 32'(mem_wr_en), 32'd0);
        chk("reset wr_addr", 32'(mem_wr_addr), 32'd0);
        chk("reset rd_addr", 32'(mem_rd_addr), 32'd0);
        chk("reset wr_data", 32'(mem_wr_data), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            run(v[i].st, v[i].f3, v[i].a, v[i].wd);
            chk($sformatf("v%0d latency", i), 32'(lat), v[i].err ? 32'd1 : 32'(v[i].nb + 1));
            chk($sformatf("v%0d rdata", i), r_rdata, v[i].exp);
            chk($sformatf("v%0d err", i), 32'(r_err), 32'(v[i].err));
            chk($sformatf("v%0d writes", i), 32'(nwr), (v[i].st && !v[i].err) ? 32'(v[i].nb) : 32'd0);
            chk($sformatf("v%0d ready after", i), 32'(r_ready), 32'd1);
            for (int k = 0; k < v[i].nb; k++)
                chk($sformatf("v%0d addr%0d", i, k), 32'(seen[k]), (v[i].a + 32'(k)) & 32'd31);
        end
        chk("illegal store left mem5", 32'(mem[5]), 32'h05);
        chk("illegal store left mem6", 32'(mem[6]), 32'h06);
        // reset wins over a same-cycle accept
        rst = 1'b1; req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'd0;
        @(posedge clk); #1;
        chk("rst prio ready", 32'(req_ready), 32'd1);
        rst = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst prio no rsp", 32'(rsp_valid), 32'd0);
        chk("rst prio still idle", 32'(req_ready), 32'd1);
        // reset in the second access cycle of SW 0
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'd0; req_wdata = 32'hA4A3A2A1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort ready", 32'(req_ready), 32'd1);
        chk("abort wr_en", 32'(mem_wr_en), 32'd0);
        chk("abort wr_data", 32'(mem_wr_data), 32'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid || mem_wr_en) pulses++;
            @(posedge clk); #1;
        end
        chk("abort no rsp", 32'(pulses), 32'd0);
        chk("abort mem0", 32'(mem[0]), 32'hA1);
        chk("abort mem1", 32'(mem[1]), 32'hA2);
        chk("abort mem2", 32'(mem[2]), 32'h01);
        chk("abort mem3", 32'(mem[3]), 32'h80);
        // back-to-back LB with req_valid held high
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'd4;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("b2b ready c%0d", i), 32'(req_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
            if (rsp_valid) begin
                pulses++;
                chk($sformatf("b2b rdata c%0d", i), rsp_rdata, 32'h00000004);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("b2b responses", 32'(pulses), 32'd4);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_byte_serial.md
Name: lsu_byte_serial

Overview:
- Load/store unit sitting between the single-cycle core's execute stage and the byte-wide data memory. It is the initiator side of the memory port.
- Each LB/LH/LW/LBU/LHU/SB/SH/SW request is broken into one byte access per cycle, little-endian.
- Bytes are assembled and sign/zero-extended for loads, and the core is stalled through a valid/ready handshake.
- Memory side: 8-bit write data, combinational 8-bit read data, one write enable.

Parameters:
- ADDR_W, 5, byte-address width of the data memory; depth = 2**ADDR_W bytes.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  core presents a request
- req_ready  out  1  block can accept a request; high only in IDLE
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address; bits above ADDR_W-1 ignored
- req_wdata  in  32  store data; low bytes used per size
- rsp_valid  out  1  one-cycle pulse, response complete
- rsp_rdata  out  32  load result (extended); 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid; 1 = illegal funct3
- mem_wr_en  out  1  byte write strobe
- mem_wr_addr  out  ADDR_W  byte write address
- mem_wr_data  out  8  byte write data
- mem_rd_addr  out  ADDR_W  byte read address (same value as mem_wr_addr)
- mem_rd_data  in  8  combinational read data for mem_rd_addr

Behaviour:
- Reset values (after the rst edge):
  - state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wr_en=0.
  - Byte counter 0, addresses 0, mem_wr_data 0.
- States:
  - IDLE -> ACCESS on req_valid&&req_ready with legal funct3.
  - IDLE -> DONE on accept with illegal funct3 (011, 110, 111); this includes a store with funct3 100/101.
  - ACCESS -> DONE when the byte counter reaches nbytes-1.
  - DONE -> IDLE unconditionally.
- Accept: latch req_store, size, signedness, addr[ADDR_W-1:0] and wdata. Clear the assembly register.
- nbytes: 1 for B/BU, 2 for H/HU, 4 for W.
- ACCESS cycle k (k=0..nbytes-1):
  - mem_wr_addr = mem_rd_addr = (base + k) mod 2**ADDR_W, so addresses wrap past the top of memory.
  - Store: mem_wr_en=1, mem_wr_data = wdata[8k+7:8k].
  - Load: mem_wr_en=0; mem_rd_data is captured into assembly byte k at the end of the cycle.
- No alignment restriction; misaligned H/W accesses are legal and simply wrap.
- Cycle timing:
  - Accept edge = cycle 0; ACCESS occupies cycles 1..nbytes; DONE at cycle nbytes+1 (rsp_valid=1).
  - req_ready=1 again at cycle nbytes+2.
  - Illegal funct3: DONE at cycle 1 with rsp_err=1, rsp_rdata=0, and no memory write.
- rsp_rdata in DONE:
  - B: sign-extend byte0. BU: zero-extend byte0.
  - H: sign-extend {byte1,byte0}. HU: zero-extend {byte1,byte0}.
  - W: {byte3,byte2,byte1,byte0}.
  - Store: 0.
- rsp_rdata and rsp_err hold their values until the next DONE; they are only meaningful while rsp_valid=1.
- req_valid while not in IDLE is ignored (req_ready=0); the core must hold the request until it is accepted.
- mem_wr_en is asserted only in ACCESS for stores; it is never high in IDLE or DONE.
- rst mid-operation: after the rst edge the block is in IDLE with mem_wr_en=0, the partial load is discarded, no rsp_valid is issued for the aborted request, and bytes already written stay written.
- rst takes priority over an accept in the same cycle.

Test Plan:
- LW addr 4, bench memory preloaded mem[i]=i -> mem_rd_addr 4,5,6,7 in cycles 1-4; rsp_valid cycle 5 with rsp_rdata=0x07060504, rsp_err=0.
- SW addr 8 wdata 0xDEADBEEF -> mem_wr_en cycles 1-4 writing EF,BE,AD,DE to 8..11; then LW 8 -> 0xDEADBEEF.
- SB 0x80 to addr 3:
  - LB 3 -> 0xFFFFFF80; LBU 3 -> 0x00000080.
  - SH 0x8001 to addr 2, then LH 2 -> 0xFFFF8001 and LHU 2 -> 0x00008001.
- LW addr 30 with mem[i]=i -> addresses 30,31,0,1; rsp_rdata=0x01001F1E.
- Illegal accesses produce no memory write:
  - funct3 011 load -> rsp_valid cycle 1, rsp_err=1, rsp_rdata=0, mem_wr_en never high.
  - Store with funct3 100 -> same response.
- rst mid-request and back-to-back requests:
  - rst during cycle 2 of SW addr 0 -> only bytes 0,1 written; mem_wr_en=0 and req_ready=1 afterwards; no rsp_valid.
  - Back-to-back LB requests with req_valid held high -> accepted every 3 cycles.
